// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy formation block and its neighbours
// (renderer, bullet-spawn logic).
package enemy_pkg;

  typedef enum logic [1:0] {
    MOVE    = 2'd0,
    DESCEND = 2'd1,
    HALT    = 2'd2
  } state_t;

  localparam int POS_W = 10;

  // Default geometry; the renderer uses the same values to draw the sprites.
  localparam int DEF_COL_PITCH = 36;
  localparam int DEF_ENEMY_W   = 24;

  // Width needed to hold a column index, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/enemy_formation_ctrl_alive_extent.sv
// Combinational extent finder: lowest and highest alive column, the number of
// alive columns and whether any column is alive at all.
module alive_extent
  import enemy_pkg::*;
#(
  parameter int COLS  = 8,
  parameter int IDX_W = idx_width(COLS),
  parameter int N_W   = $clog2(COLS + 1)
) (
  input  logic [COLS-1:0]  alive_mask,
  output logic [IDX_W-1:0] l_idx,
  output logic [IDX_W-1:0] r_idx,
  output logic [N_W-1:0]   n_alive,
  output logic             any_alive
);

  // Scan the mask once: the last hit scanning down is the lowest set bit,
  // the last hit scanning up is the highest set bit.
  always_comb begin
    l_idx   = '0;
    r_idx   = '0;
    n_alive = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (alive_mask[i]) begin
        l_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < COLS; i++) begin
      if (alive_mask[i]) begin
        r_idx   = IDX_W'(i);
        n_alive = n_alive + N_W'(1);
      end
    end
  end

  assign any_alive = |alive_mask;

endmodule

// File: rtl/enemy_formation_ctrl.sv
// Enemy formation controller: marches the formation between the rims, steps
// it down at each rim hit and speeds up as columns are destroyed.
module enemy_formation_ctrl
  import enemy_pkg::*;
#(
  parameter int COLS             = 8,
  parameter int COL_PITCH        = DEF_COL_PITCH,
  parameter int ENEMY_W          = DEF_ENEMY_W,
  parameter int STEP_X           = 12,
  parameter int STEP_Y           = 12,
  parameter int LEFT_RIM         = 36,
  parameter int RIGHT_RIM        = 630,
  parameter int INIT_X           = 36,
  parameter int INIT_Y           = 0,
  parameter int BOTTOM_Y         = 72,
  parameter int MIN_PERIOD       = 2,
  parameter int PERIOD_PER_ENEMY = 1,
  parameter int CNT_W            = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [COLS-1:0]  alive_mask,
  output logic [POS_W-1:0] posX,
  output logic [POS_W-1:0] posY,
  output logic             direction,
  output logic             endgame,
  output logic             all_dead
);

  localparam int IDX_W = idx_width(COLS);
  localparam int N_W   = $clog2(COLS + 1);
  // Rim arithmetic is done wide enough that nothing wraps and no subtraction
  // is ever needed.
  localparam int EXT_W = 12;

  state_t           state_q, state_d;
  logic [POS_W-1:0] posx_q, posx_d;
  logic [POS_W-1:0] posy_q, posy_d;
  logic             dir_q, dir_d;
  logic             endgame_q, endgame_d;
  logic             all_dead_q, all_dead_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] l_idx, r_idx;
  logic [N_W-1:0]   n_alive;
  logic             any_alive;

  logic [CNT_W-1:0] period;
  logic             step_fire;
  logic [EXT_W-1:0] right_edge, left_edge, next_y;
  logic             hit_right, hit_left;

  alive_extent #(
    .COLS (COLS)
  ) u_extent (
    .alive_mask (alive_mask),
    .l_idx      (l_idx),
    .r_idx      (r_idx),
    .n_alive    (n_alive),
    .any_alive  (any_alive)
  );

  // Fewer survivors means a shorter step period. The ">=" compare below
  // (written as cnt+1 >= period) never misses if the period shrinks mid-count.
  assign period    = CNT_W'(MIN_PERIOD) + CNT_W'(n_alive) * CNT_W'(PERIOD_PER_ENEMY);
  assign step_fire = (state_q != HALT) && ((cnt_q + CNT_W'(1)) >= period);

  assign right_edge = EXT_W'(posx_q) + EXT_W'(r_idx) * EXT_W'(COL_PITCH)
                    + EXT_W'(ENEMY_W + STEP_X);
  assign left_edge  = EXT_W'(posx_q) + EXT_W'(l_idx) * EXT_W'(COL_PITCH);
  assign hit_right  = right_edge > EXT_W'(RIGHT_RIM);
  assign hit_left   = left_edge < EXT_W'(LEFT_RIM + STEP_X);
  assign next_y     = EXT_W'(posy_q) + EXT_W'(STEP_Y);

  // Next-state and next-output logic; every decision waits for a step cycle.
  always_comb begin
    state_d    = state_q;
    posx_d     = posx_q;
    posy_d     = posy_q;
    dir_d      = dir_q;
    endgame_d  = endgame_q;
    all_dead_d = all_dead_q;
    cnt_d      = cnt_q;
    if (state_q != HALT) begin
      if (!step_fire) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = '0;
        case (state_q)
          MOVE: begin
            if (!any_alive) begin
              all_dead_d = 1'b1;
              state_d    = HALT;
            end else if (dir_q && hit_right) begin
              state_d = DESCEND;
            end else if (!dir_q && hit_left) begin
              state_d = DESCEND;
            end else if (dir_q) begin
              posx_d = posx_q + POS_W'(STEP_X);
            end else begin
              posx_d = posx_q - POS_W'(STEP_X);
            end
          end
          DESCEND: begin
            posy_d = POS_W'(next_y);
            dir_d  = ~dir_q;
            if (next_y >= EXT_W'(BOTTOM_Y)) begin
              endgame_d = 1'b1;
              state_d   = HALT;
            end else begin
              state_d = MOVE;
            end
          end
          default: begin
            state_d = HALT;
          end
        endcase
      end
    end
  end

  // State and datapath registers; reset drops everything back immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= MOVE;
      posx_q     <= POS_W'(INIT_X);
      posy_q     <= POS_W'(INIT_Y);
      dir_q      <= 1'b1;
      endgame_q  <= 1'b0;
      all_dead_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      posx_q     <= posx_d;
      posy_q     <= posy_d;
      dir_q      <= dir_d;
      endgame_q  <= endgame_d;
      all_dead_q <= all_dead_d;
      cnt_q      <= cnt_d;
    end
  end

  assign posX      = posx_q;
  assign posY      = posy_q;
  assign direction = dir_q;
  assign endgame   = endgame_q;
  assign all_dead  = all_dead_q;

endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// Directed bench for the enemy formation controller (default parameters).
module tb_enemy_formation_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] alive_mask;
  logic [9:0] posX;
  logic [9:0] posY;
  logic       direction;
  logic       endgame;
  logic       all_dead;

  int tests;
  int failures;

  enemy_formation_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .alive_mask (alive_mask),
    .posX       (posX),
    .posY       (posY),
    .direction  (direction),
    .endgame    (endgame),
    .all_dead   (all_dead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_pos(input string name, input int ex, input int ey, input logic ed);
    tests++;
    if (posX !== 10'(ex)) begin
      failures++;
      $display("[TB] FAIL %s posX got %0d expected %0d", name, posX, ex);
    end
    tests++;
    if (posY !== 10'(ey)) begin
      failures++;
      $display("[TB] FAIL %s posY got %0d expected %0d", name, posY, ey);
    end
    tests++;
    if (direction !== ed) begin
      failures++;
      $display("[TB] FAIL %s direction got %b expected %b", name, direction, ed);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    alive_mask = 8'hFF;
    clocks(3);
    check_pos("reset", 36, 0, 1'b1);
    tests++;
    if (endgame !== 1'b0 || all_dead !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset flags got %b%b expected 00", endgame, all_dead);
    end
    release_reset();
  endtask

  task automatic test_first_steps();
    clocks(9);
    check_pos("before_first_step", 36, 0, 1'b1);
    clocks(1);
    check_pos("first_step", 48, 0, 1'b1);
    clocks(9);
    check_pos("between_steps", 48, 0, 1'b1);
    clocks(1);
    check_pos("second_step", 60, 0, 1'b1);
  endtask

  task automatic test_run_right();
    clocks(24 * 10);
    check_pos("right_rim", 348, 0, 1'b1);
    clocks(10);
    check_pos("descend_entry_right", 348, 0, 1'b1);
    clocks(10);
    check_pos("descend_done_right", 348, 12, 1'b0);
  endtask

  task automatic test_run_left();
    clocks(26 * 10);
    check_pos("left_rim", 36, 12, 1'b0);
    clocks(10);
    check_pos("descend_entry_left", 36, 12, 1'b0);
    clocks(10);
    check_pos("descend_done_left", 36, 24, 1'b1);
  endtask

  task automatic test_column0_dead();
    clocks(28 * 10);
    check_pos("second_right_sweep", 348, 36, 1'b0);
    alive_mask = 8'hFE;
    clocks(8);
    check_pos("p9_before_step", 348, 36, 1'b0);
    clocks(1);
    check_pos("p9_first_step", 336, 36, 1'b0);
    clocks(28 * 9);
    check_pos("past_left_rim", 0, 36, 1'b0);
    clocks(9);
    check_pos("descend_at_zero", 0, 36, 1'b0);
    clocks(9);
    check_pos("descend_done_zero", 0, 48, 1'b1);
  endtask

  task automatic test_endgame();
    reset = 1'b0;
    #1;
    check_pos("async_reset_midrun", 36, 0, 1'b1);
    alive_mask = 8'hFF;
    release_reset();
    clocks(167 * 10);
    check_pos("before_sixth_descent", 36, 60, 1'b0);
    tests++;
    if (endgame !== 1'b0) begin
      failures++;
      $display("[TB] FAIL endgame_early got %b expected 0", endgame);
    end
    clocks(10);
    check_pos("sixth_descent", 36, 72, 1'b1);
    tests++;
    if (endgame !== 1'b1) begin
      failures++;
      $display("[TB] FAIL endgame_set got %b expected 1", endgame);
    end
    clocks(100);
    check_pos("halt_frozen", 36, 72, 1'b1);
    tests++;
    if (endgame !== 1'b1 || all_dead !== 1'b0) begin
      failures++;
      $display("[TB] FAIL halt_flags got %b%b expected 10", endgame, all_dead);
    end
    reset = 1'b0;
    #1;
    check_pos("reset_in_halt", 36, 0, 1'b1);
    tests++;
    if (endgame !== 1'b0) begin
      failures++;
      $display("[TB] FAIL endgame_after_reset got %b expected 0", endgame);
    end
  endtask

  task automatic test_all_dead();
    alive_mask = 8'hFF;
    release_reset();
    clocks(10);
    check_pos("alive_first_step", 48, 0, 1'b1);
    alive_mask = 8'h00;
    clocks(1);
    tests++;
    if (all_dead !== 1'b0) begin
      failures++;
      $display("[TB] FAIL all_dead_early got %b expected 0", all_dead);
    end
    clocks(1);
    tests++;
    if (all_dead !== 1'b1) begin
      failures++;
      $display("[TB] FAIL all_dead_set got %b expected 1", all_dead);
    end
    check_pos("all_dead_freeze", 48, 0, 1'b1);
    alive_mask = 8'hFF;
    clocks(100);
    check_pos("no_resume", 48, 0, 1'b1);
    tests++;
    if (all_dead !== 1'b1 || endgame !== 1'b0) begin
      failures++;
      $display("[TB] FAIL all_dead_sticky got %b%b expected 10", all_dead, endgame);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (all_dead !== 1'b0) begin
      failures++;
      $display("[TB] FAIL all_dead_after_reset got %b expected 0", all_dead);
    end
  endtask

  initial begin
    tests = 0;
    failures = 0;
    test_reset();
    test_first_steps();
    test_run_right();
    test_run_left();
    test_column0_dead();
    test_endgame();
    test_all_dead();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
